rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
Round-robin arbiter that shares the single common memory bus (RAM, LEDs, buttons, UART, timer, flash) between up to NUM_MASTERS requesters: CPU instruction port, CPU data port and a future DMA engine. It sits between the masters and the address decoder, replacing the fixed two-port arbitration. Each transaction holds its grant until the bus signals ready. A watchdog terminates any transaction that stalls too long and returns a fault to the master.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8); index 0 = instr, 1 = data, 2 = DMA.
TIMEOUT_CYCLES, 255, maximum busy cycles before a forced fault; 0 disables the watchdog.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_address_in  in  NUM_MASTERS*32  per-master address; slice i is [32*i +: 32]
m_read_in  in  NUM_MASTERS  per-master read request
m_write_in  in  NUM_MASTERS  per-master write request
m_write_mask_in  in  NUM_MASTERS*4  per-master byte write mask
m_write_value_in  in  NUM_MASTERS*32  per-master write data
m_read_value_out  out  NUM_MASTERS*32  read data; only the granted slice is nonzero
m_ready_out  out  NUM_MASTERS  per-master transaction complete
m_fault_out  out  NUM_MASTERS  per-master fault, qualified by m_ready_out
address_out  out  32  common bus address
read_out  out  1  common bus read
write_out  out  1  common bus write
write_mask_out  out  4  common bus byte mask
write_value_out  out  32  common bus write data
read_value_in  in  32  common bus read data
ready_in  in  1  common bus ready
fault_in  in  1  decoder fault
grant_out  out  NUM_MASTERS  one-hot current grant (debug); 0 when idle

Behaviour:
- Request: master i requests when m_read_in[i] | m_write_in[i]. It must hold the request and its operands stable until m_ready_out[i]=1.
- States: IDLE and BUSY.
  - IDLE: no bus outputs asserted. If any request is pending, register the grant and go to BUSY next cycle.
  - BUSY: bus outputs are combinationally muxed from the granted master.
- Priority: search starts at last_grant+1 and wraps modulo NUM_MASTERS. last_grant updates on every grant. Reset value of last_grant is NUM_MASTERS-1, so master 0 wins first.
- Completion: in BUSY, if ready_in=1:
  - m_ready_out[g]=1 and m_fault_out[g]=fault_in in the same cycle (combinational).
  - m_read_value_out slice g = read_value_in.
  - Next state is IDLE.
- Throughput: minimum latency is request at cycle N, bus driven and possible completion at N+1. There is one mandatory IDLE bubble between transactions, so the maximum rate is one transaction per 2 cycles.
- Stable requests: a master still requesting in the IDLE bubble after completion is treated as a new request.
- Watchdog: busy_count resets to 0 on entry to BUSY and increments each BUSY cycle without ready_in. If TIMEOUT_CYCLES!=0 and busy_count==TIMEOUT_CYCLES-1 with ready_in=0:
  - m_ready_out[g]=1, m_fault_out[g]=1, read value 0.
  - read_out/write_out remain asserted that cycle; next state is IDLE.
  - If ready_in=1 in the same cycle, the normal completion wins.
- Ungranted outputs: non-granted masters see ready=0, fault=0, read value 0. In IDLE, address_out, write_value_out and write_mask_out are 0 and read_out, write_out are 0.
- Request withdrawn in BUSY (protocol violation): read_out and write_out drop and the watchdog eventually releases the grant. No other recovery is required.
- Reset (async, any time): state=IDLE, grant_out=0, busy_count=0, last_grant=NUM_MASTERS-1. All outputs go to 0 immediately.
- Widths: busy_count is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1 bit; it does not wrap because it is cleared at timeout.

Decomposition:
- Shared package bus_pkg: typedef of the state enum {IDLE, BUSY}, and constants ADDR_W=32, DATA_W=32, MASK_W=4.
- One natural sub-module, rr_pick: a combinational rotating-priority encoder with inputs req and last_grant, outputs one-hot grant and valid. It is reusable by the DMA channel scheduler.

Test Plan:
- Master 1 reads 0x0000_0010 at cycle 0; bus ready_in=1 with read_value_in=0xDEADBEEF at cycle 1 -> address_out=0x10 and read_out=1 at cycle 1; m_ready_out=3'b010; slice 1=0xDEADBEEF; other slices 0.
- All three masters request continuously from reset, ready_in tied 1 -> grant_out sequence 001, 010, 100, 001 on cycles 1, 3, 5, 7; IDLE bubble on cycles 2, 4, 6.
- Master 2 writes 0x0001_0000 with mask 4'b0001 and value 0x55; ready_in arrives 3 cycles after grant -> write_out, write_mask_out and write_value_out stable for 4 cycles; m_ready_out[2] pulses once.
- TIMEOUT_CYCLES=4; master 0 reads with ready_in held 0 -> m_ready_out[0]=1 and m_fault_out[0]=1 on the 4th BUSY cycle; IDLE the next cycle. In a second run, ready_in=1 on that same 4th cycle -> fault=0.
- Master 1 reads 0x0400_0000 and the decoder returns ready_in=1, fault_in=1 -> m_ready_out[1]=1 and m_fault_out[1]=1 in the same cycle.
- Reset asserted mid-BUSY (cycle 2 of a stalled write) -> all outputs 0 asynchronously. After release, a request from master 2 alone is granted; with simultaneous requests, master 0 is granted first.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and widths for the common memory bus and its arbiter.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Watchdog counter width; a disabled watchdog still needs one bit.
  function automatic int unsigned busy_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 32'd1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: the first requester above
// last_grant wins, wrapping around to the lowest index.
module rr_pick #(
  parameter  int unsigned N     = 3,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [N-1:0] w_above;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  for (genvar j = 0; j < N; j++) begin : g_mask
    assign w_above[j] = (IDX_W'(j) > last_grant);
  end

  // Prefer requesters above the last winner; fall back to the full set on wrap.
  assign w_hi  = req & w_above;
  assign w_sel = (|w_hi) ? w_hi : req;
  assign grant = w_sel & (~w_sel + N'(1));
  assign valid = |req;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing the common memory bus between NUM_MASTERS
// requesters, with a per-transaction watchdog that forces a fault.
module rr_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]        m_read_in,
  input  logic [NUM_MASTERS-1:0]        m_write_in,
  input  logic [NUM_MASTERS*MASK_W-1:0] m_write_mask_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_value_in,
  output logic [NUM_MASTERS*DATA_W-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]        m_ready_out,
  output logic [NUM_MASTERS-1:0]        m_fault_out,
  output logic [ADDR_W-1:0]             address_out,
  output logic                          read_out,
  output logic                          write_out,
  output logic [MASK_W-1:0]             write_mask_out,
  output logic [DATA_W-1:0]             write_value_out,
  input  logic [DATA_W-1:0]             read_value_in,
  input  logic                          ready_in,
  input  logic                          fault_in,
  output logic [NUM_MASTERS-1:0]        grant_out
);

  localparam int unsigned IDX_W   = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W   = busy_cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned REQ_W   = $bits(bus_req_t);

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]       r_last;
  logic [CNT_W-1:0]       r_busy_cnt;

  logic [NUM_MASTERS-1:0]            w_req;
  logic [NUM_MASTERS-1:0]            w_pick;
  logic                              w_pick_valid;
  logic [IDX_W-1:0]                  w_pick_idx;
  logic [IDX_W-1:0][NUM_MASTERS-1:0] w_idx_t;
  logic [REQ_W-1:0][NUM_MASTERS-1:0] w_bus_t;
  bus_req_t                          w_bus;
  logic                              w_busy;
  logic                              w_timeout;
  logic                              w_done;

  assign w_req = m_read_in | m_write_in;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req        (w_req),
    .last_grant (r_last),
    .grant      (w_pick),
    .valid      (w_pick_valid)
  );

  assign w_busy    = (r_state == BUSY);
  assign w_timeout = w_busy && (TIMEOUT_CYCLES != 0) && !ready_in &&
                     (r_busy_cnt == CNT_W'(TO_LAST));
  assign w_done    = w_busy && (ready_in || w_timeout);

  // Muxes are AND-OR trees on the one-hot grant, so an idle arbiter
  // (grant all zero) drives every bus and master output to zero.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    localparam logic [IDX_W-1:0] IDX = IDX_W'(i);
    bus_req_t w_req_i;

    assign w_req_i = '{addr:  m_address_in[ADDR_W*i +: ADDR_W],
                       read:  m_read_in[i],
                       write: m_write_in[i],
                       mask:  m_write_mask_in[MASK_W*i +: MASK_W],
                       wdata: m_write_value_in[DATA_W*i +: DATA_W]};

    for (genvar b = 0; b < REQ_W; b++) begin : g_bus_bit
      assign w_bus_t[b][i] = r_grant[i] & w_req_i[b];
    end
    for (genvar b = 0; b < IDX_W; b++) begin : g_idx_bit
      assign w_idx_t[b][i] = w_pick[i] & IDX[b];
    end

    assign m_ready_out[i] = r_grant[i] & w_done;
    assign m_fault_out[i] = r_grant[i] & (ready_in ? fault_in : w_timeout);
    assign m_read_value_out[DATA_W*i +: DATA_W] =
      (r_grant[i] & ready_in) ? read_value_in : '0;
  end

  for (genvar b = 0; b < REQ_W; b++) begin : g_bus_or
    assign w_bus[b] = |w_bus_t[b];
  end
  for (genvar b = 0; b < IDX_W; b++) begin : g_idx_or
    assign w_pick_idx[b] = |w_idx_t[b];
  end

  assign address_out     = w_bus.addr;
  assign read_out        = w_bus.read;
  assign write_out       = w_bus.write;
  assign write_mask_out  = w_bus.mask;
  assign write_value_out = w_bus.wdata;
  assign grant_out       = r_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last     <= IDX_W'(NUM_MASTERS - 1);
      r_busy_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_state    <= BUSY;
            r_grant    <= w_pick;
            r_last     <= w_pick_idx;
            r_busy_cnt <= '0;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_busy_cnt <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_busy_cnt <= r_busy_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.
module tb_rr_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*32-1:0] m_address_in, m_write_value_in, m_read_value_out;
  logic [N-1:0]    m_read_in, m_write_in, m_ready_out, m_fault_out, grant_out;
  logic [N*4-1:0]  m_write_mask_in;
  logic [31:0]     address_out, write_value_out, read_value_in;
  logic            read_out, write_out, ready_in, fault_in;
  logic [3:0]      write_mask_out;

  int total = 0;
  int bad   = 0;

  rr_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .m_address_in     (m_address_in),
    .m_read_in        (m_read_in),
    .m_write_in       (m_write_in),
    .m_write_mask_in  (m_write_mask_in),
    .m_write_value_in (m_write_value_in),
    .m_read_value_out (m_read_value_out),
    .m_ready_out      (m_ready_out),
    .m_fault_out      (m_fault_out),
    .address_out      (address_out),
    .read_out         (read_out),
    .write_out        (write_out),
    .write_mask_out   (write_mask_out),
    .write_value_out  (write_value_out),
    .read_value_in    (read_value_in),
    .ready_in         (ready_in),
    .fault_in         (fault_in),
    .grant_out        (grant_out)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_address_in = '0; m_read_in = '0; m_write_in = '0;
    m_write_mask_in = '0; m_write_value_in = '0;
    read_value_in = '0; ready_in = 1'b0; fault_in = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at +5.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    #2;
    m_read_in = '1; ready_in = 1'b1; read_value_in = 32'hFFFF_FFFF;
    reset = 1'b1;
    #1;
    total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL rst_grant: got %b want 000", grant_out); end
    total++; if ({read_out, write_out} !== 2'b00) begin bad++; $display("FAIL rst_rw: got %b want 00", {read_out, write_out}); end
    total++; if ({address_out, write_value_out, write_mask_out} !== '0) begin bad++; $display("FAIL rst_bus: got %h/%h/%h want 0", address_out, write_value_out, write_mask_out); end
    total++; if ({m_ready_out, m_fault_out, m_read_value_out} !== '0) begin bad++; $display("FAIL rst_master: got %b/%b/%h want 0", m_ready_out, m_fault_out, m_read_value_out); end
    next_cycle();
    total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL rst_hold_grant: got %b want 000", grant_out); end
    reset = 1'b0;
    next_cycle(); #4;
    total++; if (grant_out !== 3'b001) begin bad++; $display("FAIL rst_first_grant: got %b want 001", grant_out); end
    total++; if (m_ready_out !== 3'b001) begin bad++; $display("FAIL rst_first_ready: got %b want 001", m_ready_out); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_single_read();
    logic [N*32-1:0] exp_rv;
    do_reset();
    m_read_in = 3'b010; m_address_in[32 +: 32] = 32'h0000_0010;
    #4;
    total++; if ({grant_out, read_out} !== 4'b0000) begin bad++; $display("FAIL rd_cycle0: got grant=%b read=%b want 000/0", grant_out, read_out); end
    total++; if (address_out !== 32'h0) begin bad++; $display("FAIL rd_cycle0_addr: got %h want 0", address_out); end
    next_cycle();
    ready_in = 1'b1; read_value_in = 32'hDEAD_BEEF;
    #4;
    exp_rv = {32'h0, 32'hDEAD_BEEF, 32'h0};
    total++; if (address_out !== 32'h10) begin bad++; $display("FAIL rd_addr: got %h want 00000010", address_out); end
    total++; if (read_out !== 1'b1 || write_out !== 1'b0) begin bad++; $display("FAIL rd_strobe: got r=%b w=%b want 1/0", read_out, write_out); end
    total++; if (m_ready_out !== 3'b010) begin bad++; $display("FAIL rd_ready: got %b want 010", m_ready_out); end
    total++; if (m_fault_out !== 3'b000) begin bad++; $display("FAIL rd_fault: got %b want 000", m_fault_out); end
    total++; if (m_read_value_out !== exp_rv) begin bad++; $display("FAIL rd_value: got %h want %h", m_read_value_out, exp_rv); end
    next_cycle();
    clear_inputs();
    #4;
    total++; if ({grant_out, m_ready_out} !== 6'b0) begin bad++; $display("FAIL rd_after: got %b/%b want 0", grant_out, m_ready_out); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g [8];
    logic [31:0]  exp_a [8];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    exp_a = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h300, 32'h0, 32'h100};
    do_reset();
    m_read_in = '1; ready_in = 1'b1; read_value_in = 32'h1234_5678;
    m_address_in = {32'h300, 32'h200, 32'h100};
    for (int c = 0; c < 8; c++) begin
      #4;
      total++; if (grant_out !== exp_g[c]) begin bad++; $display("FAIL rot_grant c%0d: got %b want %b", c, grant_out, exp_g[c]); end
      total++; if (m_ready_out !== exp_g[c]) begin bad++; $display("FAIL rot_ready c%0d: got %b want %b", c, m_ready_out, exp_g[c]); end
      total++; if (address_out !== exp_a[c]) begin bad++; $display("FAIL rot_addr c%0d: got %h want %h", c, address_out, exp_a[c]); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_write_stall();
    int pulses;
    pulses = 0;
    do_reset();
    m_write_in = 3'b100; m_address_in[64 +: 32] = 32'h0001_0000;
    m_write_mask_in[8 +: 4] = 4'b0001; m_write_value_in[64 +: 32] = 32'h55;
    #4;
    total++; if (write_out !== 1'b0) begin bad++; $display("FAIL wr_cycle0: got %b want 0", write_out); end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      ready_in = (c == 4);
      #4;
      total++; if ({write_out, write_mask_out, write_value_out, address_out} !== {1'b1, 4'b0001, 32'h55, 32'h0001_0000}) begin
        bad++; $display("FAIL wr_hold c%0d: got w=%b m=%b v=%h a=%h", c, write_out, write_mask_out, write_value_out, address_out); end
      total++; if (m_ready_out !== ((c == 4) ? 3'b100 : 3'b000)) begin bad++; $display("FAIL wr_ready c%0d: got %b", c, m_ready_out); end
      if (c == 4) begin
        total++; if (m_fault_out !== 3'b000) begin bad++; $display("FAIL wr_ready_wins: got %b want 000", m_fault_out); end
      end
      pulses += int'(m_ready_out[2]);
    end
    next_cycle();
    clear_inputs();
    #4;
    pulses += int'(m_ready_out[2]);
    total++; if (write_out !== 1'b0) begin bad++; $display("FAIL wr_release: got %b want 0", write_out); end
    total++; if (pulses != 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_timeout();
    logic [N-1:0]    e_flt;
    logic [N*32-1:0] e_rv;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      m_read_in = 3'b001; m_address_in[0 +: 32] = 32'h20; read_value_in = 32'hA5A5_0F0F;
      #4;
      for (int c = 1; c <= 4; c++) begin
        next_cycle();
        ready_in = (run == 1 && c == 4);
        #4;
        e_flt = (c == 4 && run == 0) ? 3'b001 : 3'b000;
        total++; if (m_ready_out !== ((c == 4) ? 3'b001 : 3'b000)) begin bad++; $display("FAIL to_ready r%0d c%0d: got %b", run, c, m_ready_out); end
        total++; if (m_fault_out !== e_flt) begin bad++; $display("FAIL to_fault r%0d c%0d: got %b want %b", run, c, m_fault_out, e_flt); end
        total++; if (read_out !== 1'b1) begin bad++; $display("FAIL to_read r%0d c%0d: got %b want 1", run, c, read_out); end
        if (c == 4) begin
          e_rv = (run == 1) ? {64'h0, 32'hA5A5_0F0F} : '0;
          total++; if (m_read_value_out !== e_rv) begin bad++; $display("FAIL to_value r%0d: got %h want %h", run, m_read_value_out, e_rv); end
        end
      end
      next_cycle();
      clear_inputs();
      #4;
      total++; if ({grant_out, read_out} !== 4'b0) begin bad++; $display("FAIL to_idle r%0d: got %b/%b want 0", run, grant_out, read_out); end
    end
  endtask

  task automatic test_decoder_fault();
    do_reset();
    m_read_in = 3'b010; m_address_in[32 +: 32] = 32'h0400_0000;
    #4;
    next_cycle();
    ready_in = 1'b1; fault_in = 1'b1;
    #4;
    total++; if (m_ready_out !== 3'b010) begin bad++; $display("FAIL dec_ready: got %b want 010", m_ready_out); end
    total++; if (m_fault_out !== 3'b010) begin bad++; $display("FAIL dec_fault: got %b want 010", m_fault_out); end
    total++; if (address_out !== 32'h0400_0000) begin bad++; $display("FAIL dec_addr: got %h want 04000000", address_out); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    m_write_in = 3'b010; m_address_in[32 +: 32] = 32'h30;
    m_write_mask_in[4 +: 4] = 4'hF; m_write_value_in[32 +: 32] = 32'h77;
    #4;
    next_cycle(); #4;
    total++; if (write_out !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", write_out); end
    next_cycle(); #2;
    reset = 1'b1;
    #1;
    total++; if ({grant_out, write_out, address_out, write_value_out, write_mask_out, m_ready_out} !== '0) begin
      bad++; $display("FAIL mid_async: got g=%b w=%b a=%h v=%h m=%b", grant_out, write_out, address_out, write_value_out, write_mask_out); end
    next_cycle();
    reset = 1'b0;
    clear_inputs();
    m_read_in = '1;
    #4;
    total++; if (grant_out !== 3'b000) begin bad++; $display("FAIL mid_idle: got %b want 000", grant_out); end
    next_cycle();
    ready_in = 1'b1;
    #4;
    total++; if (grant_out !== 3'b001) begin bad++; $display("FAIL mid_all_first: got %b want 001", grant_out); end
    next_cycle();
    clear_inputs();
    m_read_in = 3'b100;
    next_cycle();
    ready_in = 1'b1;
    #4;
    total++; if (grant_out !== 3'b100) begin bad++; $display("FAIL mid_solo2: got %b want 100", grant_out); end
    next_cycle();
    clear_inputs();
  endtask

  // Transaction-level model: a granted master owns the bus from the cycle
  // after it wins until ready_in or until TO busy cycles have passed.
  task automatic test_random();
    bit act[N]; bit isw[N]; bit done_prev[N];
    logic [31:0] adr[N]; logic [31:0] wv[N]; logic [3:0] msk[N];
    bit busy; int owner; int last; int grant_cyc; int pct; bit found; int j;
    logic [N-1:0] e_gnt, e_rdy, e_flt;
    logic [N*32-1:0] e_rv;
    logic [31:0] e_adr, e_wv; logic [3:0] e_msk; logic e_rd, e_wr;
    busy = 0; owner = 0; last = N - 1; grant_cyc = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin act[i] = 0; isw[i] = 0; done_prev[i] = 0; adr[i] = 0; wv[i] = 0; msk[i] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      pct = (cyc < 300) ? 65 : 15;
      for (int i = 0; i < N; i++) begin
        if (done_prev[i]) act[i] = 0;
        if (!act[i] && $urandom_range(0, 99) < 35) begin
          act[i] = 1; isw[i] = 1'($urandom_range(0, 1));
          adr[i] = $urandom; wv[i] = $urandom; msk[i] = 4'($urandom_range(0, 15));
        end
        m_read_in[i] = act[i] & !isw[i];
        m_write_in[i] = act[i] & isw[i];
        m_address_in[32*i +: 32] = adr[i];
        m_write_value_in[32*i +: 32] = wv[i];
        m_write_mask_in[4*i +: 4] = msk[i];
      end
      ready_in = ($urandom_range(0, 99) < pct);
      fault_in = 1'($urandom_range(0, 1));
      read_value_in = $urandom;
      #4;
      e_gnt = '0; e_rdy = '0; e_flt = '0; e_rv = '0;
      e_adr = '0; e_wv = '0; e_msk = '0; e_rd = 0; e_wr = 0;
      if (busy) begin
        e_gnt[owner] = 1'b1;
        e_adr = adr[owner]; e_wv = wv[owner]; e_msk = msk[owner];
        e_rd = act[owner] & !isw[owner]; e_wr = act[owner] & isw[owner];
        if (ready_in) begin
          e_rdy[owner] = 1'b1; e_flt[owner] = fault_in; e_rv[32*owner +: 32] = read_value_in;
        end else if (cyc == grant_cyc + TO) begin
          e_rdy[owner] = 1'b1; e_flt[owner] = 1'b1;
        end
      end
      total++; if (grant_out !== e_gnt) begin bad++; $display("FAIL rnd_grant cyc%0d: got %b want %b", cyc, grant_out, e_gnt); end
      total++; if (m_ready_out !== e_rdy) begin bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, m_ready_out, e_rdy); end
      total++; if (m_fault_out !== e_flt) begin bad++; $display("FAIL rnd_fault cyc%0d: got %b want %b", cyc, m_fault_out, e_flt); end
      total++; if (m_read_value_out !== e_rv) begin bad++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, m_read_value_out, e_rv); end
      total++; if ({address_out, read_out, write_out, write_mask_out, write_value_out} !== {e_adr, e_rd, e_wr, e_msk, e_wv}) begin
        bad++; $display("FAIL rnd_bus cyc%0d: got %h %b%b %b %h want %h %b%b %b %h", cyc, address_out, read_out, write_out,
                        write_mask_out, write_value_out, e_adr, e_rd, e_wr, e_msk, e_wv); end
      for (int i = 0; i < N; i++) done_prev[i] = e_rdy[i];
      if (busy) begin
        if (e_rdy[owner]) busy = 0;
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (!found && act[j]) begin found = 1; busy = 1; owner = j; last = j; grant_cyc = cyc; end
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_write_stall();
    test_timeout();
    test_decoder_fault();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
